// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared constants for the 4-digit seven-segment scan controller:
// segment decode patterns, digit-select patterns and edit FSM encoding.
package seven_seg_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [1:0] IDX_LAST   = 2'd3;
    localparam logic [3:0] DIGIT_MAX  = 4'd9;

    // Segment patterns, active-low, bit7 = dp (kept dark)
    localparam logic [7:0] SEG_0   = 8'hC0;
    localparam logic [7:0] SEG_1   = 8'hF9;
    localparam logic [7:0] SEG_2   = 8'hA4;
    localparam logic [7:0] SEG_3   = 8'hB0;
    localparam logic [7:0] SEG_4   = 8'h99;
    localparam logic [7:0] SEG_5   = 8'h92;
    localparam logic [7:0] SEG_6   = 8'h82;
    localparam logic [7:0] SEG_7   = 8'hD8;
    localparam logic [7:0] SEG_8   = 8'h80;
    localparam logic [7:0] SEG_9   = 8'h90;
    localparam logic [7:0] SEG_ERR = 8'h89;
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Digit selects, active-low, slot 0 is the leftmost digit
    localparam logic [3:0] DIG_0   = 4'b1110;
    localparam logic [3:0] DIG_1   = 4'b1101;
    localparam logic [3:0] DIG_2   = 4'b1011;
    localparam logic [3:0] DIG_3   = 4'b0111;
    localparam logic [3:0] DIG_OFF = 4'b1111;

    typedef enum logic [1:0] {
        VIEW  = 2'd0,
        EDIT  = 2'd1,
        CLEAR = 2'd2
    } state_e;

    // BCD to segment pattern; codes above 9 cannot occur but show "H"
    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = SEG_0;
            4'd1:    seg_decode = SEG_1;
            4'd2:    seg_decode = SEG_2;
            4'd3:    seg_decode = SEG_3;
            4'd4:    seg_decode = SEG_4;
            4'd5:    seg_decode = SEG_5;
            4'd6:    seg_decode = SEG_6;
            4'd7:    seg_decode = SEG_7;
            4'd8:    seg_decode = SEG_8;
            4'd9:    seg_decode = SEG_9;
            default: seg_decode = SEG_ERR;
        endcase
    endfunction

    function automatic logic [3:0] dig_select(input logic [1:0] idx);
        case (idx)
            2'd0:    dig_select = DIG_0;
            2'd1:    dig_select = DIG_1;
            2'd2:    dig_select = DIG_2;
            default: dig_select = DIG_3;
        endcase
    endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// Button pulses in, display drive and status out.
interface seven_seg_scan_ctrl_if;
    logic        edit_p;
    logic        inc_p;
    logic        dec_p;
    logic        right_p;
    logic        left_p;
    logic        clear_p;
    logic [7:0]  seg;
    logic [3:0]  dig;
    logic [15:0] value;
    logic [1:0]  cursor;
    logic        editing;
    logic        busy;

    // Board side: issues button pulses, watches the display
    modport master (
        output edit_p, inc_p, dec_p, right_p, left_p, clear_p,
        input  seg, dig, value, cursor, editing, busy
    );

    // Controller side
    modport slave (
        input  edit_p, inc_p, dec_p, right_p, left_p, clear_p,
        output seg, dig, value, cursor, editing, busy
    );
endinterface

// File: rtl/seven_seg_scan_ctrl_scan_timer.sv
// Digit-slot timer: slot counter, slot index, frame counting and the
// blink phase used to flash the cursor digit.
module seven_seg_scan_timer
    import seven_seg_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK     = 2,
    parameter int BLINK_DIV = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       blink_restart_i,
    output logic [1:0] scan_idx_o,
    output logic       blank_o,
    output logic       frame_tick_o,
    output logic       blink_phase_o
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FRM_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK);
    localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(BLINK_DIV - 1);

    logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]       scan_idx_q, scan_idx_d;
    logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             blink_q, blink_d;
    logic             slot_wrap;
    logic             frame_tick;

    assign slot_wrap  = (scan_cnt_q == CNT_LAST);
    assign frame_tick = slot_wrap && (scan_idx_q == IDX_LAST);

    // Next-state: slot/index wrap, frame count, blink toggle; restart wins over a tick
    always_comb begin
        scan_cnt_d  = slot_wrap ? '0 : scan_cnt_q + 1'b1;
        scan_idx_d  = slot_wrap ? scan_idx_q + 1'b1 : scan_idx_q;
        frame_cnt_d = frame_cnt_q;
        blink_d     = blink_q;
        if (blink_restart_i) begin
            frame_cnt_d = '0;
            blink_d     = 1'b0;
        end else if (frame_tick) begin
            if (frame_cnt_q == FRM_LAST) begin
                frame_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    // Timer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt_q  <= '0;
            scan_idx_q  <= '0;
            frame_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            scan_idx_q  <= scan_idx_d;
            frame_cnt_q <= frame_cnt_d;
            blink_q     <= blink_d;
        end
    end

    assign scan_idx_o    = scan_idx_q;
    assign blank_o       = (scan_cnt_q < BLANK_END);
    assign frame_tick_o  = frame_tick;
    assign blink_phase_o = blink_q;

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// 4-digit seven-segment controller: edit FSM, BCD digit registers and
// registered seg/dig drive from the scan timer.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK     = 2,
    parameter int BLINK_DIV = 25
) (
    input  logic                 clk,
    input  logic                 rst,
    seven_seg_scan_ctrl_if.slave bus
);

    state_e          state_q, state_d;
    logic [3:0][3:0] digits_q, digits_d;   // digits_q[0] is leftmost
    logic [1:0]      cursor_q, cursor_d;
    logic [1:0]      clr_idx_q, clr_idx_d;
    logic [7:0]      seg_q, seg_d;
    logic [3:0]      dig_q, dig_d;
    logic            blink_restart;

    logic [1:0]      scan_idx;
    logic            blank;
    logic            frame_tick;
    logic            blink_phase;

    seven_seg_scan_timer #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK     (BLANK),
        .BLINK_DIV (BLINK_DIV)
    ) u_timer (
        .clk             (clk),
        .rst             (rst),
        .blink_restart_i (blink_restart),
        .scan_idx_o      (scan_idx),
        .blank_o         (blank),
        .frame_tick_o    (frame_tick),
        .blink_phase_o   (blink_phase)
    );

    // Edit FSM next-state: one action per cycle, clear > edit > inc/dec > right/left
    always_comb begin
        state_d       = state_q;
        digits_d      = digits_q;
        cursor_d      = cursor_q;
        clr_idx_d     = clr_idx_q;
        blink_restart = 1'b0;
        case (state_q)
            VIEW: begin
                if (bus.clear_p) begin
                    state_d   = CLEAR;
                    clr_idx_d = '0;
                end else if (bus.edit_p) begin
                    state_d       = EDIT;
                    blink_restart = 1'b1;
                end
            end
            EDIT: begin
                if (bus.clear_p) begin
                    state_d   = CLEAR;
                    clr_idx_d = '0;
                end else if (bus.edit_p) begin
                    state_d = VIEW;
                end else if (bus.inc_p || bus.dec_p) begin
                    // inc+dec together cancel but still block right/left
                    blink_restart = 1'b1;
                    if (bus.inc_p && !bus.dec_p && digits_q[cursor_q] < DIGIT_MAX)
                        digits_d[cursor_q] = digits_q[cursor_q] + 4'd1;
                    else if (bus.dec_p && !bus.inc_p && digits_q[cursor_q] != 4'd0)
                        digits_d[cursor_q] = digits_q[cursor_q] - 4'd1;
                end else if (bus.right_p || bus.left_p) begin
                    blink_restart = 1'b1;
                    if (bus.right_p && !bus.left_p && cursor_q != IDX_LAST)
                        cursor_d = cursor_q + 2'd1;
                    else if (bus.left_p && !bus.right_p && cursor_q != 2'd0)
                        cursor_d = cursor_q - 2'd1;
                end
            end
            CLEAR: begin
                // Zero d0..d3 one per cycle; pulses are ignored here
                digits_d[clr_idx_q] = 4'd0;
                if (clr_idx_q == IDX_LAST) begin
                    state_d   = VIEW;
                    cursor_d  = '0;
                    clr_idx_d = '0;
                end else begin
                    clr_idx_d = clr_idx_q + 2'd1;
                end
            end
            default: state_d = VIEW;
        endcase
    end

    // Display drive: blank window, else slot select plus decode with cursor blink
    always_comb begin
        seg_d = SEG_OFF;
        dig_d = DIG_OFF;
        if (!blank) begin
            dig_d = dig_select(scan_idx);
            if (state_q == EDIT && blink_phase && scan_idx == cursor_q)
                seg_d = SEG_OFF;
            else
                seg_d = seg_decode(digits_q[scan_idx]);
        end
    end

    // State, digit and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= VIEW;
            digits_q  <= '0;
            cursor_q  <= '0;
            clr_idx_q <= '0;
            seg_q     <= SEG_OFF;
            dig_q     <= DIG_OFF;
        end else begin
            state_q   <= state_d;
            digits_q  <= digits_d;
            cursor_q  <= cursor_d;
            clr_idx_q <= clr_idx_d;
            seg_q     <= seg_d;
            dig_q     <= dig_d;
        end
    end

    assign bus.seg     = seg_q;
    assign bus.dig     = dig_q;
    assign bus.value   = {digits_q[0], digits_q[1], digits_q[2], digits_q[3]};
    assign bus.cursor  = cursor_q;
    assign bus.editing = (state_q == EDIT);
    assign bus.busy    = (state_q == CLEAR);

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with a small scan/blink model
// and a scoreboard of expected status after each button step.
module tb_seven_seg_scan_ctrl;

    localparam int SD = 4;
    localparam int BL = 1;
    localparam int BD = 2;

    localparam logic [5:0] P_NONE = 6'b000000;
    localparam logic [5:0] P_CLR  = 6'b100000;
    localparam logic [5:0] P_EDT  = 6'b010000;
    localparam logic [5:0] P_INC  = 6'b001000;
    localparam logic [5:0] P_DEC  = 6'b000100;
    localparam logic [5:0] P_RGT  = 6'b000010;
    localparam logic [5:0] P_LFT  = 6'b000001;

    typedef struct packed {
        logic [15:0] value;
        logic [1:0]  cursor;
        logic        editing;
        logic        busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   rc;
    exp_t sb[$];

    seven_seg_scan_ctrl_if bus();

    seven_seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK(BL), .BLINK_DIV(BD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Count active edges since reset release
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_seg(input logic [3:0] d);
        case (d)
            4'd0: m_seg = 8'hC0;  4'd1: m_seg = 8'hF9;  4'd2: m_seg = 8'hA4;
            4'd3: m_seg = 8'hB0;  4'd4: m_seg = 8'h99;  4'd5: m_seg = 8'h92;
            4'd6: m_seg = 8'h82;  4'd7: m_seg = 8'hD8;  4'd8: m_seg = 8'h80;
            4'd9: m_seg = 8'h90;  default: m_seg = 8'h89;
        endcase
    endfunction

    function automatic logic [3:0] m_dig(input int idx);
        case (idx)
            0: m_dig = 4'hE;  1: m_dig = 4'hD;  2: m_dig = 4'hB;  default: m_dig = 4'h7;
        endcase
    endfunction

    // Drive one cycle of pulses, queue the expected status, compare after the edge
    task automatic apply(input logic [5:0] p, input logic [15:0] v, input logic [1:0] cur,
                         input logic ed, input logic bz, input string tag);
        exp_t e;
        {bus.clear_p, bus.edit_p, bus.inc_p, bus.dec_p, bus.right_p, bus.left_p} = p;
        sb.push_back('{value: v, cursor: cur, editing: ed, busy: bz});
        @(posedge clk);
        #1;
        {bus.clear_p, bus.edit_p, bus.inc_p, bus.dec_p, bus.right_p, bus.left_p} = P_NONE;
        e = sb.pop_front();
        chk({tag, ".value"},   bus.value,          e.value);
        chk({tag, ".cursor"},  {14'd0, bus.cursor}, {14'd0, e.cursor});
        chk({tag, ".editing"}, {15'd0, bus.editing}, {15'd0, e.editing});
        chk({tag, ".busy"},    {15'd0, bus.busy},   {15'd0, e.busy});
    endtask

    // Check seg/dig for n cycles; rcyc is the edge of the last blink restart
    task automatic scan_check(input int n, input logic ed, input logic [1:0] cur,
                              input logic [15:0] v, input int rcyc, input string tag);
        int c, idx, ticks;
        logic [7:0] es;
        logic [3:0] ed4, d;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            c   = cyc - 1;
            idx = (c / SD) % 4;
            d   = v[15 - 4*idx -: 4];
            if ((c % SD) < BL) begin
                es  = 8'hFF;
                ed4 = 4'hF;
            end else begin
                ticks = 0;
                for (int k = rcyc + 1; k < c; k++)
                    if (k % (SD*4) == SD*4 - 1) ticks++;
                ed4 = m_dig(idx);
                es  = (ed && ((ticks / BD) % 2 == 1) && idx == int'(cur)) ? 8'hFF : m_seg(d);
            end
            chk($sformatf("%s.seg[c%0d]", tag, c), {8'd0, bus.seg}, {8'd0, es});
            chk($sformatf("%s.dig[c%0d]", tag, c), {12'd0, bus.dig}, {12'd0, ed4});
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, ".seg"},     {8'd0, bus.seg},      16'h00FF);
        chk({tag, ".dig"},     {12'd0, bus.dig},     16'h000F);
        chk({tag, ".value"},   bus.value,            16'h0000);
        chk({tag, ".cursor"},  {14'd0, bus.cursor},  16'h0000);
        chk({tag, ".editing"}, {15'd0, bus.editing}, 16'h0000);
        chk({tag, ".busy"},    {15'd0, bus.busy},    16'h0000);
    endtask

    initial begin
        {bus.clear_p, bus.edit_p, bus.inc_p, bus.dec_p, bus.right_p, bus.left_p} = P_NONE;

        // 1. reset state, then idle scan of all four slots
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outs("rst");
        @(negedge clk);
        rst = 1'b0;
        scan_check(16, 1'b0, 2'd0, 16'h0000, 0, "scan0");

        // 2. edit entry, inc/dec, cursor move, saturation at 9
        apply(P_EDT, 16'h0000, 2'd0, 1'b1, 1'b0, "edit_on");
        apply(P_INC, 16'h1000, 2'd0, 1'b1, 1'b0, "inc1");
        apply(P_INC, 16'h2000, 2'd0, 1'b1, 1'b0, "inc2");
        apply(P_INC, 16'h3000, 2'd0, 1'b1, 1'b0, "inc3");
        apply(P_RGT, 16'h3000, 2'd1, 1'b1, 1'b0, "right1");
        apply(P_DEC, 16'h3000, 2'd1, 1'b1, 1'b0, "dec_sat0");
        for (int i = 1; i <= 10; i++)
            apply(P_INC, {4'h3, 4'((i > 9) ? 9 : i), 8'h00}, 2'd1, 1'b1, 1'b0, "inc_d1");

        // 3. cursor on digit 3 = 5, then watch the blink over 4 frames
        apply(P_RGT, 16'h3900, 2'd2, 1'b1, 1'b0, "right2");
        apply(P_RGT, 16'h3900, 2'd3, 1'b1, 1'b0, "right3");
        for (int i = 1; i <= 5; i++)
            apply(P_INC, {12'h390, 4'(i)}, 2'd3, 1'b1, 1'b0, "inc_d3");
        rc = cyc - 1;
        scan_check(64, 1'b1, 2'd3, 16'h3905, rc, "blink");

        // 4. inc+dec+right cancels; clear beats edit and runs 4 cycles ignoring pulses
        apply(P_INC | P_DEC | P_RGT, 16'h3905, 2'd3, 1'b1, 1'b0, "incdec");
        apply(P_CLR | P_EDT, 16'h3905, 2'd3, 1'b0, 1'b1, "clr_start");
        apply(P_CLR,  16'h0905, 2'd3, 1'b0, 1'b1, "clr1");
        apply(P_INC,  16'h0005, 2'd3, 1'b0, 1'b1, "clr2");
        apply(P_EDT,  16'h0005, 2'd3, 1'b0, 1'b1, "clr3");
        apply(P_NONE, 16'h0000, 2'd0, 1'b0, 1'b0, "clr_done");

        // 5. VIEW ignores edits; cursor saturation in EDIT
        apply(P_INC, 16'h0000, 2'd0, 1'b0, 1'b0, "view_inc");
        apply(P_LFT, 16'h0000, 2'd0, 1'b0, 1'b0, "view_left");
        apply(P_EDT, 16'h0000, 2'd0, 1'b1, 1'b0, "edit_on2");
        apply(P_LFT, 16'h0000, 2'd0, 1'b1, 1'b0, "left_sat");
        apply(P_RGT | P_LFT, 16'h0000, 2'd0, 1'b1, 1'b0, "rl_both");
        for (int i = 1; i <= 3; i++)
            apply(P_RGT, 16'h0000, 2'(i), 1'b1, 1'b0, "right_walk");
        apply(P_RGT, 16'h0000, 2'd3, 1'b1, 1'b0, "right_sat");

        // Load 1234 for the reset test
        for (int i = 2; i >= 0; i--)
            apply(P_LFT, 16'h0000, 2'(i), 1'b1, 1'b0, "left_walk");
        apply(P_INC, 16'h1000, 2'd0, 1'b1, 1'b0, "ld_d0");
        apply(P_RGT, 16'h1000, 2'd1, 1'b1, 1'b0, "ld_r1");
        for (int i = 1; i <= 2; i++)
            apply(P_INC, {4'h1, 4'(i), 8'h00}, 2'd1, 1'b1, 1'b0, "ld_d1");
        apply(P_RGT, 16'h1200, 2'd2, 1'b1, 1'b0, "ld_r2");
        for (int i = 1; i <= 3; i++)
            apply(P_INC, {8'h12, 4'(i), 4'h0}, 2'd2, 1'b1, 1'b0, "ld_d2");
        apply(P_RGT, 16'h1230, 2'd3, 1'b1, 1'b0, "ld_r3");
        for (int i = 1; i <= 4; i++)
            apply(P_INC, {12'h123, 4'(i)}, 2'd3, 1'b1, 1'b0, "ld_d3");

        // 6. reset asserted in cycle 2 of CLEAR, then scan restarts at slot 0
        apply(P_CLR,  16'h1234, 2'd3, 1'b0, 1'b1, "clr_b");
        apply(P_NONE, 16'h0234, 2'd3, 1'b0, 1'b1, "clr_b1");
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outs("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        scan_check(16, 1'b0, 2'd0, 16'h0000, 0, "scan1");
        apply(P_NONE, 16'h0000, 2'd0, 1'b0, 1'b0, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
